// File: rtl/trace_stack.sv
// LIFO trail of variable assignments with a pop-to-last-decision backtrack sequencer.
// Optional feature: define TRACE_STACK_PEAK_EN to add the 'peak' high-water-mark output.
module trace_stack #(
    parameter int unsigned DEPTH = 128,
    parameter int unsigned VAR_W = 9,
    parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             backtrack,
    input  logic             type_in,
    input  logic             val_in,
    input  logic [VAR_W-1:0] var_in,
    output logic             out_valid,
    output logic             type_out,
    output logic             val_out,
    output logic [VAR_W-1:0] var_out,
    output logic             bt_busy,
    output logic             bt_done,
    output logic             bt_unsat,
    output logic             empty,
    output logic             full,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] dec_level,
    output logic             overflow
`ifdef TRACE_STACK_PEAK_EN
    ,
    output logic [CNT_W-1:0] peak
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = VAR_W + 2;

    typedef enum logic [0:0] {StIdle, StBt} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]   dec_level_q, dec_level_d;
    logic               overflow_q, overflow_d;
    logic               out_valid_q, out_valid_d;
    logic               type_out_q, type_out_d;
    logic               val_out_q, val_out_d;
    logic [VAR_W-1:0]   var_out_q, var_out_d;
    logic               bt_done_q, bt_done_d;
    logic               bt_unsat_q, bt_unsat_d;

    logic [EW-1:0]      mem [DEPTH];
    logic               mem_we;
    logic               do_pop;
    logic [AW-1:0]      wr_idx;
    logic [AW-1:0]      rd_idx;
    logic [EW-1:0]      top_entry;
    logic               top_is_dec;

    assign wr_idx     = count_q[AW-1:0];
    assign rd_idx     = AW'(count_q - CNT_W'(1));
    assign top_entry  = mem[rd_idx];
    assign top_is_dec = ~top_entry[EW-1];

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(DEPTH));

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        dec_level_d = dec_level_q;
        overflow_d  = overflow_q;
        out_valid_d = 1'b0;
        type_out_d  = type_out_q;
        val_out_d   = val_out_q;
        var_out_d   = var_out_q;
        bt_done_d   = 1'b0;
        bt_unsat_d  = 1'b0;
        mem_we      = 1'b0;
        do_pop      = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (backtrack) begin
                    if (empty) begin
                        // Conflict with nothing on the trail: unsatisfiable at level 0.
                        bt_done_d  = 1'b1;
                        bt_unsat_d = 1'b1;
                    end else begin
                        state_d = StBt;
                    end
                end else if (pop) begin
                    do_pop = ~empty;
                end else if (push) begin
                    if (full) begin
                        overflow_d = 1'b1;
                    end else begin
                        mem_we  = 1'b1;
                        count_d = count_q + CNT_W'(1);
                        if (!type_in) dec_level_d = dec_level_q + CNT_W'(1);
                    end
                end
            end
            StBt: begin
                // count is never zero here: entry requires count>0 and exit happens at zero.
                do_pop = 1'b1;
                if (top_is_dec) begin
                    bt_done_d = 1'b1;
                    state_d   = StIdle;
                end else if (count_q == CNT_W'(1)) begin
                    bt_done_d  = 1'b1;
                    bt_unsat_d = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (do_pop) begin
            out_valid_d                       = 1'b1;
            {type_out_d, val_out_d, var_out_d} = top_entry;
            count_d                           = count_q - CNT_W'(1);
            if (top_is_dec) dec_level_d = dec_level_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            dec_level_q <= '0;
            overflow_q  <= 1'b0;
            out_valid_q <= 1'b0;
            type_out_q  <= 1'b0;
            val_out_q   <= 1'b0;
            var_out_q   <= '0;
            bt_done_q   <= 1'b0;
            bt_unsat_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            dec_level_q <= dec_level_d;
            overflow_q  <= overflow_d;
            out_valid_q <= out_valid_d;
            type_out_q  <= type_out_d;
            val_out_q   <= val_out_d;
            var_out_q   <= var_out_d;
            bt_done_q   <= bt_done_d;
            bt_unsat_q  <= bt_unsat_d;
        end
    end

    // Storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_idx] <= {type_in, val_in, var_in};
    end

`ifdef TRACE_STACK_PEAK_EN
    logic [CNT_W-1:0] peak_q, peak_d;

    always_comb begin
        peak_d = peak_q;
        if (count_q > peak_q) peak_d = count_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) peak_q <= '0;
        else          peak_q <= peak_d;
    end

    assign peak = peak_q;
`endif

    assign out_valid = out_valid_q;
    assign type_out  = type_out_q;
    assign val_out   = val_out_q;
    assign var_out   = var_out_q;
    assign bt_busy   = (state_q == StBt);
    assign bt_done   = bt_done_q;
    assign bt_unsat  = bt_unsat_q;
    assign count     = count_q;
    assign dec_level = dec_level_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_trace_stack.sv
// Directed bench for trace_stack: a DEPTH=8 instance for function, a DEPTH=4 one for overflow.
module tb_trace_stack;

    localparam int unsigned VW = 9;
    localparam int unsigned CW = 4;   // $clog2(8+1)
    localparam int unsigned SCW = 3;  // $clog2(4+1)

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic push = 1'b0, pop = 1'b0, backtrack = 1'b0;
    logic type_in = 1'b0, val_in = 1'b0;
    logic [VW-1:0] var_in = '0;

    logic out_valid, type_out, val_out, bt_busy, bt_done, bt_unsat, empty, full, overflow;
    logic [VW-1:0] var_out;
    logic [CW-1:0] count, dec_level;

    logic s_out_valid, s_type_out, s_val_out, s_bt_busy, s_bt_done, s_bt_unsat;
    logic s_empty, s_full, s_overflow;
    logic [VW-1:0] s_var_out;
    logic [SCW-1:0] s_count, s_dec_level;
`ifdef TRACE_STACK_PEAK_EN
    logic [CW-1:0] peak;
    logic [SCW-1:0] s_peak;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    trace_stack #(.DEPTH(8), .VAR_W(VW)) dut (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .backtrack(backtrack),
        .type_in(type_in), .val_in(val_in), .var_in(var_in),
        .out_valid(out_valid), .type_out(type_out), .val_out(val_out), .var_out(var_out),
        .bt_busy(bt_busy), .bt_done(bt_done), .bt_unsat(bt_unsat),
        .empty(empty), .full(full), .count(count), .dec_level(dec_level), .overflow(overflow)
`ifdef TRACE_STACK_PEAK_EN
        , .peak(peak)
`endif
    );

    trace_stack #(.DEPTH(4), .VAR_W(VW)) dut_small (
        .clk(clk), .reset_n(reset_n), .push(push), .pop(pop), .backtrack(backtrack),
        .type_in(type_in), .val_in(val_in), .var_in(var_in),
        .out_valid(s_out_valid), .type_out(s_type_out), .val_out(s_val_out),
        .var_out(s_var_out), .bt_busy(s_bt_busy), .bt_done(s_bt_done), .bt_unsat(s_bt_unsat),
        .empty(s_empty), .full(s_full), .count(s_count), .dec_level(s_dec_level),
        .overflow(s_overflow)
`ifdef TRACE_STACK_PEAK_EN
        , .peak(s_peak)
`endif
    );

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        {push, pop, backtrack} = 3'b000;
        step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic push_op(input logic t, input logic v, input logic [VW-1:0] x);
        push = 1'b1; type_in = t; val_in = v; var_in = x;
        step();
        push = 1'b0;
    endtask

    task automatic pop_op();
        pop = 1'b1;
        step();
        pop = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({out_valid, type_out, val_out, var_out, bt_busy, bt_done, bt_unsat, overflow}
            !== '0 || {count, dec_level} !== '0 || {empty, full} !== 2'b10) begin
            miscompares++;
            $display("FAIL reset_state: ov=%b var=%0d busy=%b done=%b cnt=%0d lvl=%0d e/f=%b%b exp zeros e/f=10",
                     out_valid, var_out, bt_busy, bt_done, count, dec_level, empty, full);
        end
    endtask

    task automatic test_lifo();
        logic [VW-1:0] exp_var [3] = '{9, 7, 5};
        logic          exp_t   [3] = '{1'b1, 1'b1, 1'b0};
        logic          exp_v   [3] = '{1'b1, 1'b0, 1'b1};
        logic [CW-1:0] exp_lvl [3] = '{1, 1, 0};
        do_reset();
        push_op(1'b0, 1'b1, 9'd5);
        push_op(1'b1, 1'b0, 9'd7);
        push_op(1'b1, 1'b1, 9'd9);
        vectors++;
        if ({count, dec_level} !== {4'd3, 4'd1}) begin
            miscompares++;
            $display("FAIL lifo_fill: cnt=%0d lvl=%0d exp 3 1", count, dec_level);
        end
        for (int i = 0; i < 3; i++) begin
            pop_op();
            vectors++;
            if ({out_valid, type_out, val_out, var_out} !== {1'b1, exp_t[i], exp_v[i], exp_var[i]}
                || count !== CW'(2 - i) || dec_level !== exp_lvl[i]) begin
                miscompares++;
                $display("FAIL lifo_pop%0d: v=%b t=%b val=%b var=%0d cnt=%0d lvl=%0d exp 1 %b %b %0d %0d %0d",
                         i, out_valid, type_out, val_out, var_out, count, dec_level,
                         exp_t[i], exp_v[i], exp_var[i], 2 - i, exp_lvl[i]);
            end
        end
        step();
        vectors++;
        if ({out_valid, var_out} !== {1'b0, 9'd5}) begin
            miscompares++;
            $display("FAIL lifo_hold: v=%b var=%0d exp 0 5", out_valid, var_out);
        end
        pop_op();
        vectors++;
        if ({out_valid, count} !== {1'b0, 4'd0}) begin
            miscompares++;
            $display("FAIL pop_empty: v=%b cnt=%0d exp 0 0", out_valid, count);
        end
    endtask

    task automatic test_backtrack();
        logic [VW-1:0] exp_var [3] = '{10, 9, 8};
        do_reset();
        push_op(1'b0, 1'b1, 9'd5);
        push_op(1'b1, 1'b1, 9'd7);
        push_op(1'b0, 1'b1, 9'd8);
        push_op(1'b1, 1'b1, 9'd9);
        push_op(1'b1, 1'b1, 9'd10);
        backtrack = 1'b1;
        step();
        backtrack = 1'b0;
        vectors++;
        if ({bt_busy, out_valid, count, dec_level} !== {1'b1, 1'b0, 4'd5, 4'd2}) begin
            miscompares++;
            $display("FAIL bt_enter: busy=%b v=%b cnt=%0d lvl=%0d exp 1 0 5 2",
                     bt_busy, out_valid, count, dec_level);
        end
        // Requests during BT must be ignored.
        pop = 1'b1; push = 1'b1; var_in = 9'd20;
        for (int i = 0; i < 3; i++) begin
            step();
            vectors++;
            if ({out_valid, var_out, bt_done, bt_unsat} !== {1'b1, exp_var[i], (i == 2), 1'b0}
                || count !== CW'(4 - i) || bt_busy !== (i != 2)) begin
                miscompares++;
                $display("FAIL bt_pop%0d: v=%b var=%0d done=%b unsat=%b cnt=%0d busy=%b exp 1 %0d %b 0 %0d %b",
                         i, out_valid, var_out, bt_done, bt_unsat, count, bt_busy,
                         exp_var[i], (i == 2), 4 - i, (i != 2));
            end
        end
        pop = 1'b0; push = 1'b0;
        vectors++;
        if (dec_level !== 4'd1) begin
            miscompares++;
            $display("FAIL bt_level: lvl=%0d exp 1", dec_level);
        end
        step();
        vectors++;
        if ({out_valid, bt_done, count} !== {1'b0, 1'b0, 4'd2}) begin
            miscompares++;
            $display("FAIL bt_after: v=%b done=%b cnt=%0d exp 0 0 2", out_valid, bt_done, count);
        end
    endtask

    task automatic test_backtrack_unsat();
        do_reset();
        push_op(1'b1, 1'b0, 9'd3);
        push_op(1'b1, 1'b1, 9'd4);
        backtrack = 1'b1;
        step();
        backtrack = 1'b0;
        step();
        vectors++;
        if ({out_valid, var_out, bt_done, count} !== {1'b1, 9'd4, 1'b0, 4'd1}) begin
            miscompares++;
            $display("FAIL unsat_pop0: v=%b var=%0d done=%b cnt=%0d exp 1 4 0 1",
                     out_valid, var_out, bt_done, count);
        end
        step();
        vectors++;
        if ({out_valid, var_out, bt_done, bt_unsat, empty, bt_busy} !== {1'b1, 9'd3, 4'b1110}) begin
            miscompares++;
            $display("FAIL unsat_pop1: v=%b var=%0d done=%b unsat=%b empty=%b busy=%b exp 1 3 1 1 1 0",
                     out_valid, var_out, bt_done, bt_unsat, empty, bt_busy);
        end
        backtrack = 1'b1;
        step();
        backtrack = 1'b0;
        vectors++;
        if ({bt_done, bt_unsat, out_valid, bt_busy} !== 4'b1100) begin
            miscompares++;
            $display("FAIL bt_empty: done=%b unsat=%b v=%b busy=%b exp 1 1 0 0",
                     bt_done, bt_unsat, out_valid, bt_busy);
        end
        step();
        vectors++;
        if ({bt_done, bt_busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL bt_empty_pulse: done=%b busy=%b exp 0 0", bt_done, bt_busy);
        end
    endtask

    task automatic test_overflow();
        do_reset();
        for (int i = 1; i <= 5; i++) push_op(1'b1, 1'b0, VW'(i));
        vectors++;
        if ({s_full, s_count, s_overflow} !== {1'b1, 3'd4, 1'b1}) begin
            miscompares++;
            $display("FAIL ovf_small: full=%b cnt=%0d ovf=%b exp 1 4 1", s_full, s_count, s_overflow);
        end
        vectors++;
        if ({full, count, overflow} !== {1'b0, 4'd5, 1'b0}) begin
            miscompares++;
            $display("FAIL ovf_big: full=%b cnt=%0d ovf=%b exp 0 5 0", full, count, overflow);
        end
        pop_op();
        vectors++;
        if ({s_out_valid, s_var_out, s_count, s_overflow, s_full} !== {1'b1, 9'd4, 3'd3, 2'b10}) begin
            miscompares++;
            $display("FAIL ovf_pop: v=%b var=%0d cnt=%0d ovf=%b full=%b exp 1 4 3 1 0",
                     s_out_valid, s_var_out, s_count, s_overflow, s_full);
        end
    endtask

    task automatic test_reset_in_bt();
        do_reset();
        push_op(1'b0, 1'b1, 9'd5);
        push_op(1'b1, 1'b1, 9'd6);
        push_op(1'b1, 1'b1, 9'd7);
        backtrack = 1'b1;
        step();
        backtrack = 1'b0;
        step();
        vectors++;
        if ({out_valid, var_out, bt_busy, count} !== {1'b1, 9'd7, 1'b1, 4'd2}) begin
            miscompares++;
            $display("FAIL rst_bt_pre: v=%b var=%0d busy=%b cnt=%0d exp 1 7 1 2",
                     out_valid, var_out, bt_busy, count);
        end
        #2 reset_n = 1'b0;
        #1;
        vectors++;
        if ({out_valid, type_out, val_out, var_out, bt_busy, bt_done, bt_unsat, count, dec_level}
            !== '0) begin
            miscompares++;
            $display("FAIL rst_bt_async: v=%b var=%0d busy=%b done=%b cnt=%0d lvl=%0d exp all 0",
                     out_valid, var_out, bt_busy, bt_done, count, dec_level);
        end
        step();
        reset_n = 1'b1;
        step();
        vectors++;
        if ({bt_done, bt_busy, out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_bt_nodone: done=%b busy=%b v=%b exp 0 0 0", bt_done, bt_busy, out_valid);
        end
        push_op(1'b1, 1'b0, 9'd11);
        pop_op();
        vectors++;
        if ({out_valid, type_out, val_out, var_out, count} !== {3'b110, 9'd11, 4'd0}) begin
            miscompares++;
            $display("FAIL rst_bt_index0: v=%b t=%b val=%b var=%0d cnt=%0d exp 1 1 0 11 0",
                     out_valid, type_out, val_out, var_out, count);
        end
    endtask

    task automatic test_priority();
        do_reset();
        push_op(1'b0, 1'b1, 9'd1);
        push_op(1'b1, 1'b1, 9'd2);
        push = 1'b1; pop = 1'b1; type_in = 1'b1; var_in = 9'd30;
        step();
        push = 1'b0; pop = 1'b0;
        vectors++;
        if ({out_valid, var_out, count} !== {1'b1, 9'd2, 4'd1}) begin
            miscompares++;
            $display("FAIL push_pop_same: v=%b var=%0d cnt=%0d exp 1 2 1", out_valid, var_out, count);
        end
`ifdef TRACE_STACK_PEAK_EN
        vectors++;
        if (peak !== 4'd2) begin
            miscompares++;
            $display("FAIL peak: peak=%0d exp 2", peak);
        end
`endif
        backtrack = 1'b1; pop = 1'b1;
        step();
        backtrack = 1'b0; pop = 1'b0;
        vectors++;
        if ({bt_busy, out_valid, count} !== {2'b10, 4'd1}) begin
            miscompares++;
            $display("FAIL bt_over_pop: busy=%b v=%b cnt=%0d exp 1 0 1", bt_busy, out_valid, count);
        end
        step();
        vectors++;
        if ({out_valid, type_out, var_out, bt_done, bt_unsat, count, dec_level}
            !== {2'b10, 9'd1, 2'b10, 4'd0, 4'd0}) begin
            miscompares++;
            $display("FAIL bt_single_dec: v=%b t=%b var=%0d done=%b unsat=%b cnt=%0d lvl=%0d exp 1 0 1 1 0 0 0",
                     out_valid, type_out, var_out, bt_done, bt_unsat, count, dec_level);
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_backtrack();
        test_backtrack_unsat();
        test_overflow();
        test_reset_in_bt();
        test_priority();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
